// File: rtl/downsampling_top.sv
// 2x2 box-filter decimator: streams a W x H image out of SRAM, one read per
// cycle, and writes the rounded average of each 2x2 block to the output area.
module downsampling_top #(
   parameter int WRITE_ADDR_BASE = 115200,
   parameter int READ_ADDR_BASE  = 0,
   parameter int W               = 320,
   parameter int H               = 240,
   parameter int DW              = 16,
   parameter int AW              = 18
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          done,
   output logic [AW-1:0] raddr,
   input  logic [DW-1:0] rdata,
   output logic [AW-1:0] waddr,
   output logic [DW-1:0] wdata,
   output logic          wr_enable
);

   localparam int IW = $clog2(W / 2) + 1;
   localparam int JW = $clog2(H / 2) + 1;
   localparam logic [IW-1:0] LAST_I         = IW'(W / 2 - 1);
   localparam logic [JW-1:0] LAST_J         = JW'(H / 2 - 1);
   localparam logic [AW-1:0] ROW_STEP       = AW'(W);
   localparam logic [AW-1:0] BLOCK_ROW_STEP = AW'(2 * W);
   localparam logic [AW-1:0] COL_STEP       = AW'(2);
   localparam logic [AW-1:0] RD_BASE        = AW'(READ_ADDR_BASE);
   localparam logic [AW-1:0] WR_BASE        = AW'(WRITE_ADDR_BASE);
   localparam logic [DW+1:0] ROUND          = (DW + 2)'(2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_nextState;

   logic [IW-1:0] r_i;
   logic [JW-1:0] r_j;
   logic [1:0]    r_k;
   logic [AW-1:0] r_rowBase;
   logic [AW-1:0] r_colOff;
   logic [AW-1:0] r_raddr;

   logic          r_capValid;
   logic [1:0]    r_capK;
   logic [DW+1:0] r_acc;
   logic [AW-1:0] r_waddrNext;
   logic [AW-1:0] r_waddr;
   logic [DW-1:0] r_wdata;
   logic          r_wrEnable;

   logic          w_startRun;
   logic          w_endOfRow;
   logic          w_lastRead;
   logic          w_blockDone;
   logic [1:0]    w_kNext;
   logic [AW-1:0] w_colOffNext;
   logic [AW-1:0] w_rowBaseNext;
   logic [AW-1:0] w_raddrNext;
   logic [DW+1:0] w_sum;

   // Next read address built from the row/column bases with adders only
   always_comb begin
      w_startRun    = (r_state == S_IDLE) && start;
      w_endOfRow    = (r_i == LAST_I);
      w_lastRead    = (r_state == S_READ) && (r_k == 2'd3) && w_endOfRow && (r_j == LAST_J);
      w_kNext       = r_k + 2'd1;
      w_colOffNext  = r_colOff;
      w_rowBaseNext = r_rowBase;
      if (r_k == 2'd3) begin
         if (w_endOfRow) begin
            w_colOffNext  = '0;
            w_rowBaseNext = r_rowBase + BLOCK_ROW_STEP;
         end else begin
            w_colOffNext = r_colOff + COL_STEP;
         end
      end
      w_raddrNext = w_rowBaseNext + w_colOffNext + (w_kNext[1] ? ROW_STEP : '0) + AW'(w_kNext[0]);
   end

   // Fourth sample completes the block sum; the +2 rounds half up before the divide by 4
   always_comb begin
      w_blockDone = r_capValid && (r_capK == 2'd3);
      w_sum       = r_acc + {2'b00, rdata} + ROUND;
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state: drain waits for the final block's write before signalling done
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  if (start) w_nextState = S_READ;
         S_READ:  if (w_lastRead) w_nextState = S_DRAIN;
         S_DRAIN: if (r_wrEnable) w_nextState = S_DONE;
         S_DONE:  w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   // Read sequencer: walks blocks row by row, four reads per block, no bubbles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_i       <= '0;
         r_j       <= '0;
         r_k       <= '0;
         r_rowBase <= RD_BASE;
         r_colOff  <= '0;
         r_raddr   <= RD_BASE;
      end else if (w_startRun) begin
         r_i       <= '0;
         r_j       <= '0;
         r_k       <= '0;
         r_rowBase <= RD_BASE;
         r_colOff  <= '0;
         r_raddr   <= RD_BASE;
      end else if ((r_state == S_READ) && !w_lastRead) begin
         r_k       <= w_kNext;
         r_colOff  <= w_colOffNext;
         r_rowBase <= w_rowBaseNext;
         r_raddr   <= w_raddrNext;
         if (r_k == 2'd3) begin
            if (w_endOfRow) begin
               r_i <= '0;
               r_j <= r_j + JW'(1);
            end else begin
               r_i <= r_i + IW'(1);
            end
         end
      end
   end

   // Tag each issued read so the returning data lands in the right accumulator slot
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_capValid <= 1'b0;
         r_capK     <= '0;
      end else begin
         r_capValid <= (r_state == S_READ);
         r_capK     <= r_k;
      end
   end

   // Accumulate the block and emit one write per completed block
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc       <= '0;
         r_waddrNext <= '0;
         r_waddr     <= '0;
         r_wdata     <= '0;
         r_wrEnable  <= 1'b0;
      end else begin
         r_wrEnable <= w_blockDone;
         if (r_capValid) begin
            if (r_capK == 2'd0) begin
               r_acc <= {2'b00, rdata};
            end else begin
               r_acc <= r_acc + {2'b00, rdata};
            end
         end
         if (w_startRun) begin
            r_waddrNext <= WR_BASE;
         end else if (w_blockDone) begin
            r_waddrNext <= r_waddrNext + AW'(1);
         end
         if (w_blockDone) begin
            r_waddr <= r_waddrNext;
            r_wdata <= DW'(w_sum >> 2);
         end
      end
   end

   assign raddr     = r_raddr;
   assign waddr     = r_waddr;
   assign wdata     = r_wdata;
   assign wr_enable = r_wrEnable;
   assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_downsampling_top.sv
// Bench for downsampling_top: three instances (4x4, 2x2, default size) each with
// its own SRAM model, checked cycle by cycle against an arithmetic reference.
module tb_downsampling_top;

   localparam int AW = 18;
   localparam int DW = 16;
   localparam int WB = 115200;

   logic clk = 1'b0;
   logic rst44;
   logic rstOther;
   logic start44;
   logic start22;
   logic startDef;
   logic randRdata;

   logic [AW-1:0] raddr44, waddr44, raddr22, waddr22, raddrDef, waddrDef;
   logic [DW-1:0] rdata44, wdata44, rdata22, wdata22, rdataDef, wdataDef;
   logic          done44, wr44, done22, wr22, doneDef, wrDef;

   logic [DW-1:0] mem44 [0:15];
   logic [DW-1:0] mem22 [0:3];

   logic [AW-1:0] obsRaddr, obsWaddr;
   logic [DW-1:0] obsWdata;
   logic          obsWr, obsDone;

   int sel = 0;
   int checks = 0;
   int failures = 0;
   int lastW;

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   downsampling_top #(.W(4), .H(4)) dut44 (
      .clk(clk), .reset(rst44), .start(start44), .done(done44),
      .raddr(raddr44), .rdata(rdata44), .waddr(waddr44), .wdata(wdata44), .wr_enable(wr44)
   );

   downsampling_top #(.W(2), .H(2)) dut22 (
      .clk(clk), .reset(rstOther), .start(start22), .done(done22),
      .raddr(raddr22), .rdata(rdata22), .waddr(waddr22), .wdata(wdata22), .wr_enable(wr22)
   );

   downsampling_top dutDef (
      .clk(clk), .reset(rstOther), .start(startDef), .done(doneDef),
      .raddr(raddrDef), .rdata(rdataDef), .waddr(waddrDef), .wdata(wdataDef), .wr_enable(wrDef)
   );

   // SRAM models with one cycle of read latency; the big image is mem[a]=a[15:0]
   always @(posedge clk) begin
      rdata44  <= randRdata ? DW'($urandom) : mem44[raddr44[3:0]];
      rdata22  <= mem22[raddr22[1:0]];
      rdataDef <= raddrDef[DW-1:0];
   end

   // Route the instance under test onto one set of observation signals
   always_comb begin
      case (sel)
         0: begin
            obsRaddr = raddr44; obsWaddr = waddr44; obsWdata = wdata44; obsWr = wr44; obsDone = done44;
         end
         1: begin
            obsRaddr = raddr22; obsWaddr = waddr22; obsWdata = wdata22; obsWr = wr22; obsDone = done22;
         end
         default: begin
            obsRaddr = raddrDef; obsWaddr = waddrDef; obsWdata = wdataDef; obsWr = wrDef; obsDone = doneDef;
         end
      endcase
   end

   function automatic int memVal(input int s, input int a);
      if (s == 0) return int'(mem44[a]);
      if (s == 1) return int'(mem22[a]);
      return a % 65536;
   endfunction

   // Input address of sub-read k of output pixel n in raster order
   function automatic int readAddr(input int w, input int n, input int k);
      int j = n / (w / 2);
      int i = n % (w / 2);
      return (2 * j + k / 2) * w + 2 * i + k % 2;
   endfunction

   function automatic int blockAvg(input int s, input int w, input int n);
      int sum = 0;
      for (int k = 0; k < 4; k++) sum += memVal(s, readAddr(w, n, k));
      return (sum + 2) / 4;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int s, input logic v);
      case (s)
         0:       start44  = v;
         1:       start22  = v;
         default: startDef = v;
      endcase
   endtask

   // One start, then every cycle of the run compared with the reference model
   task automatic runCheck(input int s, input int w, input int h, input string tag,
                           input int xs1, input int xs2, input int rstCyc, output int lastWdata);
      int n = w * h / 4;
      int last = 4 * n + 3;
      int endCyc = (rstCyc > 0) ? rstCyc + 16 : last;
      int wrCount = 0;
      int holdAddr = readAddr(w, n - 1, 3);
      int expRaddr;
      bit expWr;
      lastWdata = -1;
      sel = s;
      @(negedge clk);
      applyStimulus(s, 1'b1);
      for (int c = 1; c <= endCyc; c++) begin
         @(negedge clk);
         applyStimulus(s, (c == xs1 || c == xs2) ? 1'b1 : 1'b0);
         if (rstCyc > 0 && c == rstCyc) begin
            rst44 = 1'b0;
            #1;
         end
         if (rstCyc > 0 && c >= rstCyc) begin
            checkOutput({tag, ".rst.raddr"}, 32'(obsRaddr), 0);
            checkOutput({tag, ".rst.waddr"}, 32'(obsWaddr), 0);
            checkOutput({tag, ".rst.wdata"}, 32'(obsWdata), 0);
            checkOutput({tag, ".rst.wr"}, 32'(obsWr), 0);
            checkOutput({tag, ".rst.done"}, 32'(obsDone), 0);
            if (c == rstCyc + 3) rst44 = 1'b1;
         end else begin
            expRaddr = (c <= 4 * n) ? readAddr(w, (c - 1) / 4, (c - 1) % 4) : holdAddr;
            checkOutput({tag, ".raddr"}, 32'(obsRaddr), expRaddr);
            expWr = (c >= 6) && ((c - 6) % 4 == 0) && ((c - 6) / 4 < n);
            checkOutput({tag, ".wr"}, 32'(obsWr), 32'(expWr));
            if (expWr) begin
               checkOutput({tag, ".waddr"}, 32'(obsWaddr), WB + (c - 6) / 4);
               checkOutput({tag, ".wdata"}, 32'(obsWdata), blockAvg(s, w, (c - 6) / 4));
               lastWdata = int'(obsWdata);
            end
            checkOutput({tag, ".done"}, 32'(obsDone), 32'(c == last));
            if (obsWr) wrCount++;
         end
      end
      if (rstCyc == 0) checkOutput({tag, ".wrCount"}, wrCount, n);
   endtask

   // Directed sequence of scenarios
   initial begin
      rst44     = 1'b0;
      rstOther  = 1'b0;
      start44   = 1'b0;
      start22   = 1'b0;
      startDef  = 1'b0;
      randRdata = 1'b1;
      sel       = 0;
      for (int a = 0; a < 16; a++) mem44[a] = DW'(a);
      for (int a = 0; a < 4; a++) mem22[a] = '0;

      $display("[TB] reset hold with random start/rdata");
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         start44 = 1'($urandom_range(0, 1));
         checkOutput("rsthold.raddr", 32'(obsRaddr), 0);
         checkOutput("rsthold.waddr", 32'(obsWaddr), 0);
         checkOutput("rsthold.wdata", 32'(obsWdata), 0);
         checkOutput("rsthold.wr", 32'(obsWr), 0);
         checkOutput("rsthold.done", 32'(obsDone), 0);
      end
      @(negedge clk);
      start44   = 1'b0;
      randRdata = 1'b0;
      rst44     = 1'b1;
      rstOther  = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] 4x4 identity image");
      runCheck(0, 4, 4, "id44", 0, 0, 0, lastW);

      $display("[TB] stray starts ignored, then back-to-back rerun");
      runCheck(0, 4, 4, "hs", 3, 12, 0, lastW);
      runCheck(0, 4, 4, "hs2", 0, 0, 0, lastW);

      $display("[TB] reset in the middle of a run");
      runCheck(0, 4, 4, "midrst", 0, 0, 9, lastW);
      runCheck(0, 4, 4, "rerun", 0, 0, 0, lastW);

      $display("[TB] 4x4 random images");
      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a < 16; a++) mem44[a] = DW'($urandom);
         runCheck(0, 4, 4, "rand44", 0, 0, 0, lastW);
      end

      $display("[TB] 2x2 rounding and width");
      mem22[0] = 16'd1; mem22[1] = 16'd1; mem22[2] = 16'd1; mem22[3] = 16'd2;
      runCheck(1, 2, 2, "r1112", 0, 0, 0, lastW);
      checkOutput("r1112.const", lastW, 1);
      mem22[0] = 16'd1; mem22[1] = 16'd1; mem22[2] = 16'd2; mem22[3] = 16'd2;
      runCheck(1, 2, 2, "r1122", 0, 0, 0, lastW);
      checkOutput("r1122.const", lastW, 2);
      for (int a = 0; a < 4; a++) mem22[a] = 16'hFFFF;
      runCheck(1, 2, 2, "rffff", 0, 0, 0, lastW);
      checkOutput("rffff.const", lastW, 32'hFFFF);
      for (int r = 0; r < 4; r++) begin
         for (int a = 0; a < 4; a++) mem22[a] = DW'($urandom);
         runCheck(1, 2, 2, "rand22", 0, 0, 0, lastW);
      end

      $display("[TB] default 320x240 image");
      runCheck(2, 320, 240, "def", 0, 0, 0, lastW);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/downsampling_top.md
Name: downsampling_top

Overview:
- Decimating counterpart of the upsampling engine: reads a W x H 16-bit image from SRAM and writes a (W/2) x (H/2) image.
- Each output pixel is the rounded average of one non-overlapping 2x2 input block.
- Uses the same split SRAM interface as the upsampler: a read-only port with 1-cycle read latency and a write-only port.
- A start/done handshake lets the top-level sequencer chain it with the upsampler.

Parameters:
- WRITE_ADDR_BASE, 115200, word address of output pixel (0,0).
- READ_ADDR_BASE, 0, word address of input pixel (0,0).
- W, 320, input width in pixels; must be even and >= 2.
- H, 240, input height in pixels; must be even and >= 2.
- DW, 16, pixel/data width.
- AW, 18, SRAM address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; all state clears while low.
- start  input  1  single-cycle request; sampled only in IDLE.
- done  output  1  one-cycle pulse after the last output write.
- raddr  output  AW  SRAM read address.
- rdata  input  DW  SRAM read data, valid the cycle after raddr.
- waddr  output  AW  SRAM write address.
- wdata  output  DW  SRAM write data.
- wr_enable  output  1  SRAM write strobe, one cycle per output pixel.

Behaviour:
- Reset values (reset low): raddr=READ_ADDR_BASE, waddr=0, wdata=0, wr_enable=0, done=0, FSM=IDLE. All counters and accumulator are 0.
- FSM states:
  - IDLE -> READ on start=1.
  - READ -> DRAIN after the read for the last block's k=3 is issued.
  - DRAIN -> DONE after the last write.
  - DONE -> IDLE unconditionally after 1 cycle; done=1 only in DONE.
- start is ignored in READ, DRAIN and DONE.
- Block order: output row j = 0..H/2-1 (outer), output column i = 0..W/2-1, sub-read k = 0..3 (inner).
- Read address: raddr = READ_ADDR_BASE + (2j + k[1])*W + 2i + k[0].
  - Order within a block: top-left, top-right, bottom-left, bottom-right.
  - Addresses are generated with incremental row/column base counters; no multipliers.
- Timing, with start sampled at edge 0:
  - Read k of block n is presented on raddr during cycle 1+4n+k; exactly one read per cycle, no bubbles.
  - rdata is captured at the end of cycle 2+4n+k.
  - Accumulator width is DW+2 bits. k=0 loads the accumulator; k=1..3 add to it.
- Write for block n is asserted during cycle 6+4n:
  - wr_enable=1.
  - waddr = WRITE_ADDR_BASE + j*(W/2) + i.
  - wdata = (sum + 2) >> 2, i.e. round half up. The result always fits in DW bits.
  - Outside write cycles wr_enable=0; waddr/wdata hold their last values.
- Completion: N = W*H/4 output pixels. Last write at cycle 4N+2; done pulses in cycle 4N+3. The block is back in IDLE at cycle 4N+4 and can accept a new start then.
- Outside READ, raddr holds its last value. No reads are issued in DRAIN or DONE.
- Wrap-around:
  - End of output column: i resets to 0, j increments.
  - End of output row: the input row base advances by 2W.
  - No address wraps past 2^AW for legal parameters. Defaults span read 0..76799 and write 115200..134399.
- Reset mid-operation: everything returns to reset values at once. No further writes, no done pulse, and no partial output is completed. The next start begins from block 0.

Test Plan:
- Reset: hold reset=0 with random start/rdata -> raddr=READ_ADDR_BASE, waddr=0, wdata=0, wr_enable=0, done=0 throughout.
- W=4, H=4, SRAM model with mem[a]=a:
  - raddr sequence is 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15.
  - Writes at cycles 6,10,14,18 give (waddr,wdata) = (base,3), (base+1,5), (base+2,11), (base+3,13).
  - done pulses at cycle 19.
- Rounding/width, W=2, H=2:
  - Block {1,1,1,2} -> wdata=1.
  - Block {1,1,2,2} -> wdata=2.
  - Block {0xFFFF x4} -> wdata=0xFFFF (no overflow).
- Handshake, W=4, H=4: pulse start again at cycles 3 and 12 -> ignored, address sequence unchanged. A start at cycle 20 after done -> full identical second run.
- Reset mid-run, W=4, H=4: assert reset low during cycle 9 -> outputs at reset values immediately. No write at cycle 10 or later, no done. A fresh start then reproduces the second scenario's results.
- Defaults 320x240, mem[a]=a[15:0]:
  - Exactly 19200 wr_enable pulses, each a single cycle.
  - waddr runs 115200..134399 contiguous and increasing.
  - wdata matches the reference model.
  - done at cycle 76803.
